// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, divisor record and divisor calculator for the UART baud generator
package uart_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OVS_DEF    = 16;

  typedef struct packed {
    logic [DIV_W_DEF-1:0]  di;
    logic [FRAC_W_DEF-1:0] df;
  } div_t;

  // Oversample period in 1/2^FRAC_W clk units, rounded to nearest.
  function automatic div_t calc_div(input longint unsigned clk_freq,
                                    input longint unsigned baud);
    longint unsigned den;
    longint unsigned q;
    div_t            r;
    den  = baud * longint'(OVS_DEF);
    q    = ((clk_freq << FRAC_W_DEF) + den / 64'd2) / den;
    r.di = q[FRAC_W_DEF +: DIV_W_DEF];
    r.df = q[FRAC_W_DEF-1:0];
    return r;
  endfunction

endpackage

// File: rtl/uart_frac_acc.sv
// rtl/uart_frac_acc.sv - fractional phase accumulator; carry stretches the following period by one cycle
module uart_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic [FRAC_W-1:0] inc_i,
  output logic              carry_o
);

  logic [FRAC_W-1:0] acc_q;
  logic              carry_q;
  logic [FRAC_W:0]   sum;

  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, inc_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (clr_i) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (step_i) begin
      acc_q   <= sum[FRAC_W-1:0];
      carry_q <= sum[FRAC_W];
    end
  end

  assign carry_o = carry_q;

endmodule

// File: rtl/uart_baudgen_frac.sv
// rtl/uart_baudgen_frac.sv - fractional baud generator: os_tick every div_int(+carry) cycles, bit_tick every OVS os_ticks
module uart_baudgen_frac
  import uart_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OVS    = OVS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic              div_load_i,
  output logic              os_tick_o,
  output logic              bit_tick_o,
  output logic              cfg_err_o,
  output logic              upd_pend_o
);

  localparam int             CW   = DIV_W + 1;
  localparam int             BW   = $clog2(OVS);
  localparam logic [BW-1:0]  BMAX = BW'(OVS - 1);

  logic [DIV_W-1:0]  sh_int_q, act_int_q, act_int_d;
  logic [FRAC_W-1:0] sh_frac_q, act_frac_q, act_frac_d;
  logic              upd_pend_q, upd_pend_d;
  logic              run_q, run_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc, period;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              os_tick_q, bit_tick_q, cfg_err_q;
  logic              tick, xfer, act_valid_d, carry;

  // run_q marks the first enabled edge as the phase origin, so the first tick lands div_int edges later.
  always_comb begin
    period      = CW'(act_int_q) + CW'(carry);
    cnt_inc     = cnt_q + CW'(1);
    tick        = run_q && en_i && (cnt_inc == period);
    xfer        = upd_pend_q && (!run_q || tick);
    act_int_d   = xfer ? sh_int_q  : act_int_q;
    act_frac_d  = xfer ? sh_frac_q : act_frac_q;
    act_valid_d = (act_int_d > DIV_W'(1));
    run_d       = en_i && act_valid_d;
    upd_pend_d  = div_load_i || (upd_pend_q && !xfer);

    cnt_d = cnt_inc;
    if (!run_q || !run_d || tick) begin
      cnt_d = '0;
    end

    bcnt_d = bcnt_q;
    if (!run_d) begin
      bcnt_d = '0;
    end else if (tick) begin
      bcnt_d = (bcnt_q == BMAX) ? '0 : bcnt_q + BW'(1);
    end
  end

  uart_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_acc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (!run_d),
    .step_i  (tick),
    .inc_i   (act_frac_d),
    .carry_o (carry)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_int_q   <= '0;
      sh_frac_q  <= '0;
      act_int_q  <= '0;
      act_frac_q <= '0;
      upd_pend_q <= 1'b0;
      run_q      <= 1'b0;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      if (div_load_i) begin
        sh_int_q  <= div_int_i;
        sh_frac_q <= div_frac_i;
      end
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      upd_pend_q <= upd_pend_d;
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      os_tick_q  <= tick;
      bit_tick_q <= tick && (bcnt_q == BMAX);
      cfg_err_q  <= !act_valid_d;
    end
  end

  assign os_tick_o  = os_tick_q;
  assign bit_tick_o = bit_tick_q;
  assign cfg_err_o  = cfg_err_q;
  assign upd_pend_o = upd_pend_q;

endmodule

// File: tb/tb_uart_baudgen_frac.sv
// tb/tb_uart_baudgen_frac.sv - table-driven and directed-sequence bench for uart_baudgen_frac
module tb_uart_baudgen_frac;
  import uart_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [15:0] div_int_i;
  logic [3:0]  div_frac_i;
  logic        div_load_i;
  logic        os_tick_o, bit_tick_o, cfg_err_o, upd_pend_o;

  int nvec = 0;
  int nerr = 0;
  int cc   = 0;

  typedef struct {
    int di;
    int df;
    int first;
    int span;
    int p2;
    int fbit;
  } vec_t;

  vec_t tv[7];

  uart_baudgen_frac #(
    .DIV_W  (16),
    .FRAC_W (4),
    .OVS    (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .div_int_i  (div_int_i),
    .div_frac_i (div_frac_i),
    .div_load_i (div_load_i),
    .os_tick_o  (os_tick_o),
    .bit_tick_o (bit_tick_o),
    .cfg_err_o  (cfg_err_o),
    .upd_pend_o (upd_pend_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      cc++;
    end
  endtask

  task automatic wait_tick(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      step(1);
      if (os_tick_o) begin
        at = cc;
        break;
      end
    end
  endtask

  task automatic load(input int di, input int df);
    div_int_i  = 16'(di);
    div_frac_i = 4'(df);
    div_load_i = 1'b1;
    step(1);
    div_load_i = 1'b0;
  endtask

  initial begin
    int   t;
    int   nt;
    int   fb;
    int   tk[17];
    div_t r;

    // di, df, first tick, span of 16 periods, 2nd inter-tick period, first bit_tick
    tv[0] = '{4,   0,   4,   64,   4,   64};
    tv[1] = '{4,   8,   4,   72,   5,   71};
    tv[2] = '{27,  2,   27,  434,  27,  433};
    tv[3] = '{2,   15,  2,   47,   3,   46};
    tv[4] = '{3,   0,   3,   48,   3,   48};
    tv[5] = '{5,   1,   5,   81,   5,   80};
    tv[6] = '{100, 0,   100, 1600, 100, 1600};

    rst_ni     = 1'b0;
    en_i       = 1'b0;
    div_int_i  = '0;
    div_frac_i = '0;
    div_load_i = 1'b0;

    #12;
    chk("reset_outputs", int'({os_tick_o, bit_tick_o, cfg_err_o, upd_pend_o}), 0);
    rst_ni = 1'b1;
    step(1);
    chk("post_reset_cfg_err", int'(cfg_err_o), 1);
    chk("post_reset_upd_pend", int'(upd_pend_o), 0);

    r = calc_div(64'd50_000_000, 64'd115200);
    chk("calc_div_int", int'(r.di), 27);
    chk("calc_div_frac", int'(r.df), 2);

    for (int v = 0; v < 7; v++) begin
      en_i = 1'b0;
      load(tv[v].di, tv[v].df);
      chk($sformatf("v%0d_upd_pend_set", v), int'(upd_pend_o), 1);
      step(1);
      chk($sformatf("v%0d_upd_pend_clr", v), int'(upd_pend_o), 0);
      en_i = 1'b1;
      step(1);
      cc = 0;
      nt = 0;
      fb = -1;
      for (int c = 0; c < 18 * (tv[v].di + 1) + 8 && nt < 17; c++) begin
        step(1);
        if (os_tick_o) begin
          tk[nt] = cc;
          nt++;
        end
        if (bit_tick_o && fb < 0) fb = cc;
      end
      chk($sformatf("v%0d_tick_count", v), nt, 17);
      if (nt == 17) begin
        chk($sformatf("v%0d_first", v), tk[0], tv[v].first);
        chk($sformatf("v%0d_span16", v), tk[16] - tk[0], tv[v].span);
        chk($sformatf("v%0d_period2", v), tk[2] - tk[1], tv[v].p2);
        chk($sformatf("v%0d_first_bit", v), fb, tv[v].fbit);
      end
      en_i = 1'b0;
      step(1);
    end

    // rate change mid-period, then a load on the exact boundary cycle
    load(10, 0);
    step(1);
    en_i = 1'b1;
    step(1);
    cc = 0;
    wait_tick(30, t);
    chk("rc_first", t, 10);
    step(3);
    load(6, 0);
    chk("rc_pend_mid", int'(upd_pend_o), 1);
    wait_tick(30, t);
    chk("rc_old_period_done", t, 20);
    chk("rc_pend_clr", int'(upd_pend_o), 0);
    wait_tick(30, t);
    chk("rc_new_period", t, 26);
    step(5);
    div_int_i  = 16'd8;
    div_load_i = 1'b1;
    step(1);
    div_load_i = 1'b0;
    chk("rc_bnd_tick", int'(os_tick_o), 1);
    chk("rc_bnd_pend", int'(upd_pend_o), 1);
    wait_tick(30, t);
    chk("rc_bnd_still6", t, 38);
    chk("rc_bnd_pend_clr", int'(upd_pend_o), 0);
    wait_tick(30, t);
    chk("rc_bnd_now8", t, 46);

    // invalid divisor then recovery
    load(1, 0);
    wait_tick(30, t);
    chk("inv_last_tick", t, 54);
    chk("inv_cfg_err", int'(cfg_err_o), 1);
    wait_tick(100, t);
    chk("inv_no_ticks", t, -1);
    load(3, 0);
    cc = 0;
    wait_tick(30, t);
    chk("inv_rec_first", t, 4);
    chk("inv_rec_cfg_err", int'(cfg_err_o), 0);
    wait_tick(30, t);
    chk("inv_rec_second", t, 7);

    // async reset right after a tick edge
    wait_tick(30, t);
    chk("rst_pre_tick", t, 10);
    rst_ni = 1'b0;
    en_i   = 1'b0;
    #1;
    chk("rst_async_outputs", int'({os_tick_o, bit_tick_o, cfg_err_o, upd_pend_o}), 0);
    #2;
    rst_ni = 1'b1;
    step(1);
    chk("rst_rel_cfg_err", int'(cfg_err_o), 1);

    // disable mid-period and re-enable: phase and accumulator restart
    load(4, 8);
    step(1);
    en_i = 1'b1;
    step(1);
    cc = 0;
    wait_tick(30, t);
    chk("dis_first", t, 4);
    wait_tick(30, t);
    chk("dis_second", t, 8);
    step(2);
    en_i = 1'b0;
    step(1);
    chk("dis_no_tick", int'(os_tick_o), 0);
    en_i = 1'b1;
    step(1);
    cc = 0;
    wait_tick(30, t);
    chk("reen_first", t, 4);
    wait_tick(30, t);
    chk("reen_second", t, 8);
    wait_tick(30, t);
    chk("reen_third_acc0", t, 13);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
